// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

    // Transaction sequencing: wait for a request, hold the memory handshake, report completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Cycles valid may stay high without ready before the transfer is aborted.
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester found scanning upward from last+1.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Requester index examined at each priority rank (rank 0 = highest, just after last).
    logic [IDX_W-1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(last_i) + 1 + gi) % NUM_REQ);
        end
    endgenerate

    // Walk ranks from lowest to highest priority so the highest-priority hit is assigned last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                idx_o = cand[k];
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding valid/ready memory port among NUM_REQ requesters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int WIDTH      = `WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [WIDTH-1:0]             rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_WIDTH-1:0]        addr,
    output logic [WIDTH-1:0]             wdata,
    output logic                         wr_rd,
    output logic                         valid,
    input  logic                         ready,
    input  logic [WIDTH-1:0]             rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic                 wr_rd_q, wr_rd_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] req_addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]      req_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // State and datapath registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_rd_q     <= 1'b0;
            valid_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_rd_q     <= wr_rd_d;
            valid_q     <= valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state: accept a winner, wait for ready or give up at the timeout, then report.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_rd_d     = wr_rd_q;
        valid_d     = valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    last_d  = pick_idx;
                    gnt_d   = pick_idx;
                    addr_d  = req_addr_arr[pick_idx];
                    wdata_d = req_wdata_arr[pick_idx];
                    wr_rd_d = req_wr_rd[pick_idx];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // ready on the final allowed edge still counts as a normal completion
                if (ready) begin
                    state_d     = RESP;
                    valid_d     = 1'b0;
                    rsp_rdata_d = wr_rd_q ? '0 : rdata;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    valid_d     = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Handshake strobes toward the requesters, decoded from the current state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE) begin
            req_ready = pick_grant;
        end
        if (state_q == RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign wr_rd     = wr_rd_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomised and directed bench for mem_rr_arbiter against a transaction-level reference model.
module tb_mem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_wr_rd = '0;
    logic [N*AW-1:0]   req_addr  = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              wr_rd;
    logic              valid;
    logic              ready = 1'b0;
    logic [DW-1:0]     rdata = '0;

    mem_rr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .WIDTH      (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr_rd (req_wr_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .wdata     (wdata),
        .wr_rd     (wr_rd),
        .valid     (valid),
        .ready     (ready),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: where the current transfer is, who owns it, and what it carries.
    typedef enum int {M_IDLE, M_BUSY, M_RESP} mphase_e;
    mphase_e       m_phase;
    int            m_last, m_g, m_busy_cycles;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_wr, m_err;

    function automatic int rr_winner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_last = N - 1; m_g = 0; m_busy_cycles = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_wr = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_check();
        int w;
        logic [N-1:0] exp_rr, exp_rsp;
        if (!rst) begin
            chk("rst_valid", valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            return;
        end
        w = (m_phase == M_IDLE) ? rr_winner(req_valid, m_last) : -1;
        exp_rr = '0;
        if (w >= 0) exp_rr[w] = 1'b1;
        chk("req_ready", req_ready, exp_rr);
        chk("valid", valid, (m_phase == M_BUSY) ? 1 : 0);
        if (m_phase == M_BUSY) begin
            chk("addr", addr, m_addr);
            chk("wdata", wdata, m_wdata);
            chk("wr_rd", wr_rd, m_wr);
        end
        exp_rsp = '0;
        if (m_phase == M_RESP) exp_rsp[m_g] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_rsp);
        if (m_phase == M_RESP) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
        end
    endtask

    // Advance the model across the coming edge using the (stable) current inputs.
    task automatic model_step();
        int w;
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            M_IDLE: begin
                w = rr_winner(req_valid, m_last);
                if (w >= 0) begin
                    m_g = w; m_last = w;
                    m_addr  = req_addr[w*AW +: AW];
                    m_wdata = req_wdata[w*DW +: DW];
                    m_wr    = req_wr_rd[w];
                    m_busy_cycles = 1;
                    m_phase = M_BUSY;
                end
            end
            M_BUSY: begin
                if (ready) begin
                    m_rdata = m_wr ? '0 : rdata; m_err = 1'b0; m_phase = M_RESP;
                end else if (m_busy_cycles == TO) begin
                    m_rdata = '0; m_err = 1'b1; m_phase = M_RESP;
                end else begin
                    m_busy_cycles++;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        req_valid = '0;
        neg(); adv();
        neg(); adv();
        rst = 1'b1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_wr_rd[i] = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    int vcnt, rspcnt;
    logic [N-1:0]  rsp_vec;
    logic          rsp_e;
    logic [DW-1:0] rsp_d;

    // Run until one response is seen; ready_after < 0 keeps ready low, else ready rises after that many valid cycles.
    task automatic run(input int budget, input int ready_after);
        logic [N-1:0] acc;
        vcnt = 0; rspcnt = 0;
        if (ready_after >= 0) ready = (ready_after == 0);
        for (int c = 0; c < budget && rspcnt == 0; c++) begin
            neg();
            if (valid) vcnt++;
            if (rsp_valid != '0) begin
                rspcnt++; rsp_vec = rsp_valid; rsp_e = rsp_err; rsp_d = rsp_rdata;
            end
            acc = req_ready;
            adv();
            req_valid &= ~acc;
            if (ready_after >= 0) ready = (vcnt >= ready_after);
        end
        chk("run_got_response", rspcnt, 1);
    endtask

    initial begin
        int grants[$];
        int exp_order[5];
        logic [N-1:0] acc;
        int mode;

        exp_order = '{0, 1, 2, 3, 0};
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_valid", valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_addr", addr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_wr_rd", wr_rd, 0);
        rst = 1'b1;

        // Single read from requester 2, memory ready immediately.
        set_req(2, 1'b0, 16'h0010, 32'h0);
        ready = 1'b1; rdata = 32'hDEADBEEF;
        neg();
        chk("sr_req_ready_c0", req_ready, 4'b0100);
        chk("sr_valid_c0", valid, 0);
        adv(); req_valid = '0;
        neg();
        chk("sr_valid_c1", valid, 1);
        chk("sr_addr_c1", addr, 16'h0010);
        adv();
        neg();
        chk("sr_rsp_valid_c2", rsp_valid, 4'b0100);
        chk("sr_rsp_rdata_c2", rsp_rdata, 32'hDEADBEEF);
        chk("sr_rsp_err_c2", rsp_err, 0);
        chk("sr_valid_c2", valid, 0);
        adv();
        neg();
        chk("sr_rsp_valid_c3", rsp_valid, 0);
        adv();

        // Backpressure: ready low for 5 busy cycles, then high.
        set_req(0, 1'b0, 16'h0020, 32'h0);
        ready = 1'b0; rdata = 32'h0BADF00D;
        run(20, 5);
        chk("bp_valid_cycles", vcnt, 6);
        chk("bp_rsp_vec", rsp_vec, 4'b0001);
        chk("bp_rsp_err", rsp_e, 0);
        chk("bp_rsp_rdata", rsp_d, 32'h0BADF00D);

        // Timeout: ready never comes for a write from requester 1.
        set_req(1, 1'b1, 16'h0030, 32'hCAFE0001);
        ready = 1'b0;
        run(40, -1);
        chk("to_valid_cycles", vcnt, 16);
        chk("to_rsp_vec", rsp_vec, 4'b0010);
        chk("to_rsp_err", rsp_e, 1);
        chk("to_rsp_rdata", rsp_d, 0);

        // Following read completes normally.
        set_req(3, 1'b0, 16'h0040, 32'h0);
        rdata = 32'h12345678;
        run(10, 0);
        chk("post_to_rsp_vec", rsp_vec, 4'b1000);
        chk("post_to_rsp_err", rsp_e, 0);
        chk("post_to_rsp_rdata", rsp_d, 32'h12345678);

        // Reset while busy: valid drops without a clock edge.
        set_req(2, 1'b0, 16'h0050, 32'h0);
        ready = 1'b0;
        neg(); adv(); req_valid = '0;
        neg(); adv();
        chk("mid_valid_before_rst", valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_async_valid", valid, 0);
        chk("mid_async_rsp_valid", rsp_valid, 0);
        model_reset();
        neg(); adv();
        neg(); adv();
        rst = 1'b1;
        set_req(0, 1'b0, 16'h0060, 32'h0);
        set_req(3, 1'b0, 16'h0070, 32'h0);
        ready = 1'b1;
        neg();
        chk("mid_after_rst_winner", req_ready, 4'b0001);
        adv(); req_valid[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin neg(); acc = req_ready; adv(); req_valid &= ~acc; end

        // Contention: all four hold writes continuously from reset.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(16'h0100 + i), DW'(32'hA0000000 + i));
        ready = 1'b1;
        for (int c = 0; c < 40 && grants.size() < 5; c++) begin
            neg();
            for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
            adv();
        end
        chk("ct_grant_count", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++) chk($sformatf("ct_grant_%0d", k), grants[k], exp_order[k]);

        // Randomised traffic with alternating responsive and stalling memory.
        req_valid = '0;
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) mode = $urandom_range(0, 2);
            neg();
            acc = req_ready;
            adv();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0 || (acc[i] && $urandom_range(0, 1) == 0))
                        set_req(i, 1'($urandom), AW'($urandom), $urandom);
                    else
                        req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 60) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            case (mode)
                0: ready = ($urandom_range(0, 2) != 0);
                1: ready = ($urandom_range(0, 4) == 0);
                default: ready = ($urandom_range(0, 40) == 0);
            endcase
            rdata = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter and sequencer that shares one valid/ready memory port among `NUM_REQ` requesters. Each requester hands over one read or write request at a time. The arbiter drives the single-outstanding memory handshake and returns read data or an error response to the granted requester. It sits between the requester agents/blocks and the memory slave port (`addr`, `wdata`, `rdata`, `valid`, `ready`, `wr_rd`).

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..16)
- `ADDR_WIDTH`, `` `ADDR_WIDTH ``: memory address width
- `WIDTH`, `` `WIDTH ``: data width
- `TIMEOUT`, 16: max cycles `valid` is held without `ready` before abort (≥2)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous active-low reset
- `req_valid` in NUM_REQ: request pending, per requester
- `req_wr_rd` in NUM_REQ: 1 = write, 0 = read
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened, requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wdata` in NUM_REQ*WIDTH: flattened, same packing
- `req_ready` out NUM_REQ: one-hot accept pulse
- `rsp_valid` out NUM_REQ: one-hot completion pulse
- `rsp_rdata` out WIDTH: read data, valid with `rsp_valid`
- `rsp_err` out 1: timeout abort flag, valid with `rsp_valid`
- `addr` out ADDR_WIDTH: memory address
- `wdata` out WIDTH: memory write data
- `wr_rd` out 1: memory direction
- `valid` out 1: memory request valid
- `ready` in 1: memory accept
- `rdata` in WIDTH: memory read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:** if any `req_valid` is set, pick the winner g by round-robin starting at `last+1` (mod NUM_REQ).
  - Drive `req_ready[g]=1` combinationally that cycle.
  - At the edge: latch the winner's addr/wdata/wr_rd onto the memory outputs, set `valid=1`, `last<=g`, go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:** `valid` and memory outputs are held stable.
  - Edge with `ready=1`: capture `rdata` (reads only; writes capture 0), `valid<=0`, go to RESP.
  - Edge with `ready=0`: timeout counter +1. When the counter reaches TIMEOUT-1 without `ready`: `valid<=0`, `rsp_err<=1`, captured data 0, go to RESP.
- **RESP:** `rsp_valid[g]=1` for exactly one cycle, with `rsp_rdata` and `rsp_err`; then go to IDLE.
- Requesters must hold `req_valid` and payload until `req_ready`. A requester may re-request immediately after its `rsp_valid`.
- Timeout counter width is `$clog2(TIMEOUT)`. It clears on entry to BUSY and does not wrap.
- Round-robin pointer `last` resets to NUM_REQ-1, so requester 0 wins first after reset.
- All memory-side outputs come from flops; no combinational path from `ready` to any output.

## Timing
- Reset values: `valid`, `wr_rd`, `addr`, `wdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `req_ready` all 0; state IDLE; `last`=NUM_REQ-1.
- Best case: accept at cycle 0, `valid` high in cycle 1, `ready` in cycle 1, `rsp_valid` in cycle 2, IDLE in cycle 3.
  - Throughput is one transfer per 3 cycles.
- `ready` arriving while in IDLE or RESP is ignored.
- A `req_valid` drop before acceptance is legal: the requester simply is not granted.
- Simultaneous requests: exactly one `req_ready` bit per accept, never two.
- Timeout abort: `valid` falls on the edge where the count hits TIMEOUT-1. `ready` arriving on that same edge wins, giving a normal completion with no error.
- `rst` asserted mid-transaction: all flops clear immediately, `valid` drops asynchronously, and the in-flight request is abandoned with no `rsp_valid`.

## Structure
- Package `mem_arb_pkg`: `state_e` enum {IDLE, BUSY, RESP}; default `TIMEOUT` localparam.
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: request vector, `last`.
  - Outputs: one-hot grant, encoded index, any-request flag.
- The top holds the FSM, the payload/response registers and the timeout counter.

## Test plan
- **Single read:** req 2 reads addr 0x10, memory answers `ready=1`, `rdata`=0xDEADBEEF on the first BUSY cycle → `req_ready[2]` at cycle 0, `valid` only in cycle 1, `rsp_valid[2]`=1 with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0 in cycle 2.
- **Contention:** all 4 requesters hold writes continuously from reset → grant order 0,1,2,3,0; each `wdata`/`addr` matches its requester; never more than one `req_ready` bit set.
- **Backpressure:** `ready` held 0 for 5 cycles then 1 → `addr`/`wdata`/`wr_rd` stable through all 6 BUSY cycles; exactly one `rsp_valid`, `rsp_err`=0.
- **Timeout:** TIMEOUT=16, `ready` never asserted → `valid` high for exactly 16 cycles, then `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0; the next request proceeds normally.
- **Reset mid-BUSY:** `rst` driven low while `valid`=1 → `valid` goes to 0 without waiting for a clock edge, no `rsp_valid`; after release, requester 0 wins when 0 and 3 request together.
